// File: rtl/mpu6050_pkg.sv
// Shared MPU-6050 register map, init-table entry type and sequencer state encoding.
package mpu6050_pkg;

    localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
    localparam logic [7:0] ACCEL_CONFIG = 8'h1C;
    localparam logic [7:0] GYRO_CONFIG  = 8'h1B;
    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } init_entry_t;

    typedef enum logic [2:0] {
        INIT_ISSUE,
        INIT_WAIT,
        READ_IDLE,
        READ_ISSUE,
        READ_WAIT,
        ERROR
    } seq_state_t;

endpackage

// File: rtl/mpu_init_rom.sv
// Combinational init table: maps an entry index to the register write replayed after reset.
module mpu_init_rom
    import mpu6050_pkg::*;
(
    input  logic [2:0]  i_idx,
    output init_entry_t o_entry
);

    always_comb begin
        o_entry = '{addr: 8'h00, data: 8'h00};
        case (i_idx)
            3'd0:    o_entry = '{addr: PWR_MGMT_1,   data: 8'h00};
            3'd1:    o_entry = '{addr: ACCEL_CONFIG, data: 8'h00};
            3'd2:    o_entry = '{addr: GYRO_CONFIG,  data: 8'h00};
            default: o_entry = '{addr: 8'h00,        data: 8'h00};
        endcase
    end

endmodule

// File: rtl/mpu_i2c_sequencer.sv
// Drives the MPU-6050 I2C driver: replays the init table, then issues periodic burst reads.
// Optional watchdog on driver completion is enabled by defining SEQ_TIMEOUT_EN.
module mpu_i2c_sequencer
    import mpu6050_pkg::*;
#(
    parameter int         INIT_LEN  = 3,
    parameter logic [7:0] READ_ADDR = ACCEL_XOUT_H,
    parameter int         READ_LEN  = 6,
    parameter int         PERIOD    = 1000,
    parameter int         TIMEOUT   = 4095
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    output logic            drv_run_req,
    output logic            drv_r_en,
    output logic [7:0]      drv_reg_addr,
    output logic [7:0]      drv_send_data,
    output logic [2:0]      drv_num_data,
    input  logic            drv_end_flag,
    input  logic [7:0][7:0] drv_received_data,
    output logic [7:0][7:0] sample_data,
    output logic            sample_valid,
    output logic            init_done,
    output logic            busy,
    output logic            error
);

    localparam int            PW          = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD - 1);
    localparam logic [2:0]    INIT_LAST   = 3'(INIT_LEN - 1);

    seq_state_t      r_state, w_state_n;
    logic [2:0]      r_idx, w_idx_n;
    logic [PW-1:0]   r_period;
    logic            r_run_req, w_run_req_n;
    logic            r_r_en, w_r_en_n;
    logic [7:0]      r_addr, w_addr_n;
    logic [7:0]      r_data, w_data_n;
    logic [2:0]      r_num, w_num_n;
    logic [7:0][7:0] r_sample, w_sample_n;
    logic            r_valid, w_valid_n;
    logic            r_init_done, w_init_done_n;
    init_entry_t     w_entry;
    logic [7:0][7:0] w_capture;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_wd, w_wd_n;
    logic          r_error, w_error_n;
`else
    logic          w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT;
`endif

    mpu_init_rom u_rom (
        .i_idx   (r_idx),
        .o_entry (w_entry)
    );

    // Bytes past the burst length are never meaningful, so they are masked before capture.
    always_comb begin
        w_capture = '0;
        for (int i = 0; i < 8; i++) begin
            w_capture[i] = (i < READ_LEN) ? drv_received_data[i] : 8'h00;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_idx_n       = r_idx;
        w_run_req_n   = r_run_req;
        w_r_en_n      = r_r_en;
        w_addr_n      = r_addr;
        w_data_n      = r_data;
        w_num_n       = r_num;
        w_sample_n    = r_sample;
        w_valid_n     = 1'b0;
        w_init_done_n = r_init_done;

        case (r_state)
            INIT_ISSUE: begin
                w_run_req_n = 1'b1;
                w_r_en_n    = 1'b0;
                w_addr_n    = w_entry.addr;
                w_data_n    = w_entry.data;
                w_num_n     = 3'd1;
                w_state_n   = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (drv_end_flag) begin
                    w_run_req_n = 1'b0;
                    if (r_idx == INIT_LAST) begin
                        w_init_done_n = 1'b1;
                        w_state_n     = READ_IDLE;
                    end else begin
                        w_idx_n   = r_idx + 3'd1;
                        w_state_n = INIT_ISSUE;
                    end
                end
            end
            READ_IDLE: begin
                if (r_period == PERIOD_LAST && enable) begin
                    w_state_n = READ_ISSUE;
                end
            end
            READ_ISSUE: begin
                w_run_req_n = 1'b1;
                w_r_en_n    = 1'b1;
                w_addr_n    = READ_ADDR;
                w_data_n    = 8'h00;
                w_num_n     = 3'(READ_LEN);
                w_state_n   = READ_WAIT;
            end
            READ_WAIT: begin
                if (drv_end_flag) begin
                    w_sample_n  = w_capture;
                    w_valid_n   = 1'b1;
                    w_run_req_n = 1'b0;
                    w_state_n   = READ_IDLE;
                end
            end
            ERROR: begin
                w_run_req_n = 1'b0;
            end
            default: begin
                w_run_req_n = 1'b0;
                w_state_n   = INIT_ISSUE;
            end
        endcase

`ifdef SEQ_TIMEOUT_EN
        // A completion arriving on the expiry cycle wins over the timeout.
        w_wd_n    = '0;
        w_error_n = r_error;
        if ((r_state == INIT_WAIT || r_state == READ_WAIT) && !drv_end_flag) begin
            if (r_wd == TW'(TIMEOUT - 1)) begin
                w_error_n   = 1'b1;
                w_run_req_n = 1'b0;
                w_state_n   = ERROR;
            end else begin
                w_wd_n = r_wd + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT_ISSUE;
            r_idx       <= '0;
            r_period    <= '0;
            r_run_req   <= 1'b0;
            r_r_en      <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_num       <= '0;
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_init_done <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_wd        <= '0;
            r_error     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_idx       <= w_idx_n;
            r_run_req   <= w_run_req_n;
            r_r_en      <= w_r_en_n;
            r_addr      <= w_addr_n;
            r_data      <= w_data_n;
            r_num       <= w_num_n;
            r_sample    <= w_sample_n;
            r_valid     <= w_valid_n;
            r_init_done <= w_init_done_n;
`ifdef SEQ_TIMEOUT_EN
            r_wd        <= w_wd_n;
            r_error     <= w_error_n;
`endif
            // Free-running so read instants stay on a fixed grid regardless of driver latency.
            if (r_init_done) begin
                r_period <= (r_period == PERIOD_LAST) ? '0 : r_period + 1'b1;
            end
        end
    end

    assign drv_run_req   = r_run_req;
    assign drv_r_en      = r_r_en;
    assign drv_reg_addr  = r_addr;
    assign drv_send_data = r_data;
    assign drv_num_data  = r_num;
    assign sample_data   = r_sample;
    assign sample_valid  = r_valid;
    assign init_done     = r_init_done;
    assign busy          = r_run_req;
`ifdef SEQ_TIMEOUT_EN
    assign error         = r_error;
`else
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_mpu_i2c_sequencer.sv
// Scoreboard bench for mpu_i2c_sequencer with a behavioural I2C driver model of variable latency.
// Watchdog scenario is exercised when SEQ_TIMEOUT_EN is defined.
module tb_mpu_i2c_sequencer;

    localparam int         PERIOD   = 20;
    localparam int         READ_LEN = 6;
    localparam int         TIMEOUT  = 50;
    localparam logic [19:0] READ_REQ = {1'b1, 8'h3B, 8'h00, 3'd6};

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            drv_run_req;
    logic            drv_r_en;
    logic [7:0]      drv_reg_addr;
    logic [7:0]      drv_send_data;
    logic [2:0]      drv_num_data;
    logic            drv_end_flag;
    logic [7:0][7:0] drv_received_data;
    logic [7:0][7:0] sample_data;
    logic            sample_valid;
    logic            init_done;
    logic            busy;
    logic            error;

    always #5 clk = ~clk;

    mpu_i2c_sequencer #(
        .INIT_LEN  (3),
        .READ_ADDR (8'h3B),
        .READ_LEN  (READ_LEN),
        .PERIOD    (PERIOD),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .drv_run_req       (drv_run_req),
        .drv_r_en          (drv_r_en),
        .drv_reg_addr      (drv_reg_addr),
        .drv_send_data     (drv_send_data),
        .drv_num_data      (drv_num_data),
        .drv_end_flag      (drv_end_flag),
        .drv_received_data (drv_received_data),
        .sample_data       (sample_data),
        .sample_valid      (sample_valid),
        .init_done         (init_done),
        .busy              (busy),
        .error             (error)
    );

    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;
    logic [19:0] expReq[$];
    logic [63:0] expSample[$];
    bit          pending, modelOn, expDrop, prevRun, expInitDoneNext, checkGap;
    int          waitCnt, latency, reqCount, initEnds, lastReadCycle, expGap;
    logic [19:0] curReq;
    logic [7:0]  dataBase;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic pushInitWrites();
        expReq.delete();
        expReq.push_back({1'b0, 8'h6B, 8'h00, 3'd1});
        expReq.push_back({1'b0, 8'h1C, 8'h00, 3'd1});
        expReq.push_back({1'b0, 8'h1B, 8'h00, 3'd1});
    endtask

    // One clock cycle: observe at the falling edge, then run the driver model.
    task automatic applyStimulus();
        logic [19:0] obs;
        logic [19:0] expR;
        logic [63:0] expS;
        @(negedge clk);
        cycle++;
        drv_end_flag      = 1'b0;
        drv_received_data = {8{8'hEE}};
        if (expDrop) begin
            checkOutput("runreq_drop", drv_run_req, 0);
            expDrop = 1'b0;
        end
        if (expInitDoneNext) begin
            checkOutput("init_done_rise", init_done, 1);
            expInitDoneNext = 1'b0;
        end
        if (sample_valid) begin
            if (expSample.size() == 0) checkOutput("valid_unexpected", sample_valid, 0);
            else checkOutput("sample_data", sample_data, expSample.pop_front());
        end
        if (drv_run_req && !prevRun) begin
            obs  = {drv_r_en, drv_reg_addr, drv_send_data, drv_num_data};
            expR = (expReq.size() > 0) ? expReq.pop_front() : READ_REQ;
            checkOutput("req_fields", obs, expR);
            checkOutput("busy", busy, 1);
            checkOutput("overlap", pending, 0);
            reqCount++;
            if (drv_r_en) begin
                if (checkGap) checkOutput("req_gap", cycle - lastReadCycle, expGap);
                lastReadCycle = cycle;
            end
            if (modelOn) begin
                pending = 1'b1;
                waitCnt = 0;
                curReq  = obs;
            end
        end else if (pending) begin
            waitCnt++;
            if (waitCnt >= latency) begin
                checkOutput("req_stable", {drv_r_en, drv_reg_addr, drv_send_data, drv_num_data}, curReq);
                drv_end_flag = 1'b1;
                pending      = 1'b0;
                expDrop      = 1'b1;
                if (curReq[19]) begin
                    expS = '0;
                    for (int i = 0; i < 8; i++) begin
                        drv_received_data[i] = dataBase + 8'(i) + 8'd1;
                        if (i < READ_LEN) expS[i*8 +: 8] = dataBase + 8'(i) + 8'd1;
                    end
                    expSample.push_back(expS);
                    dataBase = dataBase + 8'h10;
                end else begin
                    initEnds++;
                    if (initEnds == 3) begin
                        checkOutput("init_done_pre", init_done, 0);
                        expInitDoneNext = 1'b1;
                    end
                end
            end
        end
        prevRun = drv_run_req;
    endtask

    task automatic waitRequests(input int n, input int budget);
        int target;
        int k;
        target = reqCount + n;
        k = 0;
        while (reqCount < target && k < budget) begin
            applyStimulus();
            k++;
        end
        checkOutput("req_wait", reqCount >= target, 1);
    endtask

    task automatic waitInitDone(input int budget);
        int k;
        k = 0;
        while ((initEnds < 3 || expInitDoneNext) && k < budget) begin
            applyStimulus();
            k++;
        end
        checkOutput("init_wait", init_done, 1);
    endtask

    initial begin
        int startCount;
        int k;
        rst = 1'b1; enable = 1'b0; drv_end_flag = 1'b0; drv_received_data = '0;
        latency = 10; modelOn = 1'b1; pending = 1'b0; expDrop = 1'b0; prevRun = 1'b0;
        expInitDoneNext = 1'b0; checkGap = 1'b0; reqCount = 0; initEnds = 0;
        lastReadCycle = 0; expGap = PERIOD; dataBase = 8'h00; waitCnt = 0; curReq = '0;
        pushInitWrites();

        repeat (3) applyStimulus();
        checkOutput("rst_run_req", drv_run_req, 0);
        checkOutput("rst_init_done", init_done, 0);
        checkOutput("rst_valid", sample_valid, 0);
        checkOutput("rst_sample", sample_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_addr", {drv_r_en, drv_reg_addr, drv_send_data, drv_num_data}, 0);
        rst = 1'b0;

        // Init replay, then periodic reads on a fixed 20-cycle grid.
        waitRequests(3, 200);
        waitInitDone(50);
        enable = 1'b1;
        waitRequests(1, 60);
        checkGap = 1'b1;
        expGap   = PERIOD;
        waitRequests(3, 100);

        // Disable while a read is in flight: it still completes, two ticks are dropped.
        enable = 1'b0;
        startCount = reqCount;
        repeat (45) applyStimulus();
        checkOutput("disabled_no_req", reqCount - startCount, 0);
        checkOutput("inflight_delivered", expSample.size(), 0);
        enable = 1'b1;
        expGap = 3 * PERIOD;
        waitRequests(1, 40);

        // Driver slower than the period: every other tick is dropped.
        latency = 30;
        expGap  = 2 * PERIOD;
        waitRequests(3, 200);

        // Reset in the middle of a read, followed by a stale completion.
        latency = 10;
        repeat (3) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        checkOutput("midrst_run_req", drv_run_req, 0);
        checkOutput("midrst_init_done", init_done, 0);
        checkOutput("midrst_sample", sample_data, 0);
        pending = 1'b0; expDrop = 1'b0; checkGap = 1'b0; initEnds = 0;
        expSample.delete();
        pushInitWrites();
        rst = 1'b0;
        drv_end_flag = 1'b1;
        waitRequests(3, 200);
        waitInitDone(50);
        waitRequests(1, 60);

        enable = 1'b0;
        k = 0;
        while ((pending || expDrop || expSample.size() > 0) && k < 100) begin
            applyStimulus();
            k++;
        end
        checkOutput("drain", expSample.size(), 0);

`ifdef SEQ_TIMEOUT_EN
        // Driver never answers: watchdog trips and the sequencer goes quiet.
        rst = 1'b1;
        modelOn = 1'b0;
        applyStimulus();
        rst = 1'b0;
        pushInitWrites();
        waitRequests(1, 10);
        k = 0;
        while (!error && k < 80) begin
            applyStimulus();
            k++;
        end
        checkOutput("timeout_cycle", k, TIMEOUT);
        checkOutput("timeout_error", error, 1);
        checkOutput("timeout_run_req", drv_run_req, 0);
        startCount = reqCount;
        repeat (100) applyStimulus();
        checkOutput("error_no_req", reqCount - startCount, 0);
        checkOutput("error_sticky", error, 1);
`else
        checkOutput("error_off", error, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
